// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned IMEM_BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W              = 32;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_RECV,
    BOOT_WRITE,
    BOOT_RELEASE,
    BOOT_RUN,
    BOOT_ERROR
  } boot_state_t;

  // Latched instruction word and its end-of-program marker.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } boot_word_t;

  // Byte k of a word, MSB first: k=0 returns [31:24].
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word, input logic [1:0] k);
    logic [WORD_W-1:0] sh;
    sh = word >> (5'd24 - {k, 3'b000});
    return sh[7:0];
  endfunction

endpackage

// File: rtl/boot_checksum.sv
// Running 32-bit modulo sum of loaded words, compared against a trailing checksum word.
// Present only when BOOT_CHECKSUM_EN is defined.
`ifdef BOOT_CHECKSUM_EN
module boot_checksum
  import imem_boot_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] check,
  output logic              match_c
);

  logic [WORD_W-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + word;
    end
  end

  assign match_c = (sum_q == check);

endmodule
`endif

// File: rtl/imem_boot_loader.sv
// Streams 32-bit words into byte-addressed instruction RAM (MSB byte first), then releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word after the last program word.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_BYTES     = 1024,
  parameter int unsigned ADDR_W         = $clog2(IMEM_BYTES),
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int unsigned BASE_W = ADDR_W + 1;
  localparam int unsigned WL_W   = ADDR_W - 1;
  localparam int unsigned CNT_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [BASE_W-1:0] BASE_FULL = BASE_W'(IMEM_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RELEASE_CYCLES - 1);

  boot_state_t       state_q, state_n;
  logic [BASE_W-1:0] base_q, base_n;
  logic [1:0]        idx_q, idx_n;
  boot_word_t        pay_q, pay_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [WL_W-1:0]   words_n;

  logic              in_ready_n, imem_we_n, core_reset_n, done_n, error_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [7:0]        imem_wdata_n;

`ifdef BOOT_CHECKSUM_EN
  logic ck_phase_q, ck_phase_n;
  logic ck_clear, ck_add, ck_match_c;

  boot_checksum u_checksum (
    .clock   (clock),
    .reset   (reset),
    .clear   (ck_clear),
    .add     (ck_add),
    .word    (in_word),
    .check   (in_word),
    .match_c (ck_match_c)
  );
`endif

  // Next-state logic; registered outputs are decoded from the next state.
  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    idx_n   = idx_q;
    pay_n   = pay_q;
    cnt_n   = cnt_q;
    words_n = words_loaded;
`ifdef BOOT_CHECKSUM_EN
    ck_phase_n = ck_phase_q;
    ck_clear   = 1'b0;
    ck_add     = 1'b0;
`endif

    unique case (state_q)
      BOOT_IDLE, BOOT_RUN, BOOT_ERROR: begin
        if (start) begin
          state_n = BOOT_RECV;
          base_n  = '0;
          words_n = '0;
`ifdef BOOT_CHECKSUM_EN
          ck_phase_n = 1'b0;
          ck_clear   = 1'b1;
`endif
        end
      end
      BOOT_RECV: begin
        if (in_valid) begin
`ifdef BOOT_CHECKSUM_EN
          if (ck_phase_q) begin
            ck_phase_n = 1'b0;
            state_n    = ck_match_c ? BOOT_RELEASE : BOOT_ERROR;
            cnt_n      = CNT_LOAD;
          end else
`endif
          if (base_q == BASE_FULL) begin
            state_n = BOOT_ERROR;
          end else begin
            pay_n.data = in_word;
            pay_n.last = in_last;
            idx_n      = 2'd0;
            state_n    = BOOT_WRITE;
`ifdef BOOT_CHECKSUM_EN
            ck_add = 1'b1;
`endif
          end
        end
      end
      BOOT_WRITE: begin
        idx_n = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          words_n = words_loaded + WL_W'(1);
          base_n  = base_q + BASE_W'(IMEM_BYTES_PER_WORD);
          if (pay_q.last) begin
`ifdef BOOT_CHECKSUM_EN
            state_n    = BOOT_RECV;
            ck_phase_n = 1'b1;
`else
            state_n = BOOT_RELEASE;
            cnt_n   = CNT_LOAD;
`endif
          end else begin
            state_n = BOOT_RECV;
          end
        end
      end
      BOOT_RELEASE: begin
        if (cnt_q == '0) begin
          state_n = BOOT_RUN;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = BOOT_IDLE;
    endcase

    in_ready_n   = (state_n == BOOT_RECV);
    imem_we_n    = (state_n == BOOT_WRITE);
    imem_addr_n  = imem_we_n ? (base_n[ADDR_W-1:0] + ADDR_W'(idx_n)) : '0;
    imem_wdata_n = imem_we_n ? word_byte(pay_n.data, idx_n) : 8'h00;
    core_reset_n = (state_n != BOOT_RUN);
    done_n       = (state_n == BOOT_RUN);
    error_n      = (state_n == BOOT_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= BOOT_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      pay_q        <= '0;
      cnt_q        <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      ck_phase_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      base_q       <= base_n;
      idx_q        <= idx_n;
      pay_q        <= pay_n;
      cnt_q        <= cnt_n;
      words_loaded <= words_n;
      in_ready     <= in_ready_n;
      imem_we      <= imem_we_n;
      imem_addr    <= imem_addr_n;
      imem_wdata   <= imem_wdata_n;
      core_reset   <= core_reset_n;
      done         <= done_n;
      error        <= error_n;
`ifdef BOOT_CHECKSUM_EN
      ck_phase_q   <= ck_phase_n;
`endif
    end
  end

endmodule
